// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles the decode-stage hazard sequencer's signals.
//   master : the pipeline side. It drives the decoded ID fields, the EX redirect
//            and the debug requests, and it receives the stall/flush/bubble
//            controls, the forward selects and the status bits.
//   slave  : hazard_ctrl itself.
// Decode inputs : id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used,
//                 id_rs2_used, id_rd_addr, id_reg_we, id_is_load
// Control inputs: ex_redirect, dbg_halt_req, dbg_resume
// Outputs       : pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
//                 fwd_rs1_sel, fwd_rs2_sel, halted, pipe_empty
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic                  id_reg_we;
    logic                  id_is_load;
    logic                  ex_redirect;
    logic                  dbg_halt_req;
    logic                  dbg_resume;
    logic                  pc_stall;
    logic                  if_id_stall;
    logic                  if_id_flush;
    logic                  id_ex_bubble;
    logic [1:0]            fwd_rs1_sel;
    logic [1:0]            fwd_rs2_sel;
    logic                  halted;
    logic                  pipe_empty;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_rd_addr, id_reg_we, id_is_load, ex_redirect, dbg_halt_req,
               dbg_resume,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble, fwd_rs1_sel,
               fwd_rs2_sel, halted, pipe_empty
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_rd_addr, id_reg_we, id_is_load, ex_redirect, dbg_halt_req,
               dbg_resume,
        output pc_stall, if_id_stall, if_id_flush, id_ex_bubble, fwd_rs1_sel,
               fwd_rs2_sel, halted, pipe_empty
    );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Decode-stage sequencer for the 5-stage core. It keeps shadow tags of the EX,
// MEM and WB occupants and uses them to derive stall, flush and bubble
// controls plus the EX operand forward selects. It also runs the debug
// halt/drain FSM (RUN -> DRAIN -> HALTED -> RUN).
// Ports:
//   clk   : core clock
//   reset : synchronous, active-high; clears all state
//   bus   : hazard_ctrl_if.slave (decode fields, redirect, debug requests in;
//           stall/flush/bubble, forward selects, halted, pipe_empty out)
// Build option:
//   HAZARD_CTRL_FWD_EN : when defined, only a load in EX stalls its consumer
//                        (1 cycle), and ALU results are forwarded through
//                        fwd_rs*_sel. When undefined, any RAW hit in EX, MEM or
//                        WB stalls, and the forward selects are tied to 0.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_ADDR_W        = 5,
    parameter int FLUSH_ON_REDIRECT = 1
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [REG_ADDR_W-1:0] X0       = {REG_ADDR_W{1'b0}};
    localparam logic                  FLUSH_EN = (FLUSH_ON_REDIRECT != 0);

    state_t                state_q;
    logic                  halted_q;
    logic                  ex_v_q, ex_we_q, mem_v_q, mem_we_q, wb_v_q;
    logic [REG_ADDR_W-1:0] ex_rd_q, mem_rd_q;
`ifdef HAZARD_CTRL_FWD_EN
    logic                  ex_ld_q;
    logic [1:0]            fwd_rs1_q, fwd_rs2_q;
    logic [1:0]            fwd_rs1_d, fwd_rs2_d;
`else
    logic                  wb_we_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;
    logic                  rs1_wb_s, rs2_wb_s;
`endif
    logic rs1_ex_s, rs2_ex_s, rs1_mem_s, rs2_mem_s;
    logic stall_s, run_s, issue_s, hold_s, pipe_empty_s;

    // RAW hit of one ID source against one shadow tag; x0 never hits.
    function automatic logic hit_f(
        input logic                  id_v,
        input logic                  used,
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  tag_v,
        input logic                  tag_we,
        input logic [REG_ADDR_W-1:0] tag_rd
    );
        return id_v & used & (rs != X0) & tag_v & tag_we & (tag_rd == rs);
    endfunction

    assign rs1_ex_s  = hit_f(bus.id_valid, bus.id_rs1_used, bus.id_rs1_addr, ex_v_q,  ex_we_q,  ex_rd_q);
    assign rs2_ex_s  = hit_f(bus.id_valid, bus.id_rs2_used, bus.id_rs2_addr, ex_v_q,  ex_we_q,  ex_rd_q);
    assign rs1_mem_s = hit_f(bus.id_valid, bus.id_rs1_used, bus.id_rs1_addr, mem_v_q, mem_we_q, mem_rd_q);
    assign rs2_mem_s = hit_f(bus.id_valid, bus.id_rs2_used, bus.id_rs2_addr, mem_v_q, mem_we_q, mem_rd_q);

`ifdef HAZARD_CTRL_FWD_EN
    // Only load data is not ready to forward while the load is still in EX.
    assign stall_s = (rs1_ex_s | rs2_ex_s) & ex_ld_q;

    // Youngest producer wins: the EX occupant sits in EX/MEM during the
    // consumer's EX cycle, and the MEM occupant sits in MEM/WB.
    always_comb begin
        fwd_rs1_d = 2'd0;
        fwd_rs2_d = 2'd0;
        if (issue_s) begin
            if (rs1_ex_s) begin
                fwd_rs1_d = 2'd1;
            end else if (rs1_mem_s) begin
                fwd_rs1_d = 2'd2;
            end else begin
                fwd_rs1_d = 2'd0;
            end
            if (rs2_ex_s) begin
                fwd_rs2_d = 2'd1;
            end else if (rs2_mem_s) begin
                fwd_rs2_d = 2'd2;
            end else begin
                fwd_rs2_d = 2'd0;
            end
        end else begin
            fwd_rs1_d = 2'd0;
            fwd_rs2_d = 2'd0;
        end
    end

    assign bus.fwd_rs1_sel = fwd_rs1_q;
    assign bus.fwd_rs2_sel = fwd_rs2_q;
`else
    assign rs1_wb_s = hit_f(bus.id_valid, bus.id_rs1_used, bus.id_rs1_addr, wb_v_q, wb_we_q, wb_rd_q);
    assign rs2_wb_s = hit_f(bus.id_valid, bus.id_rs2_used, bus.id_rs2_addr, wb_v_q, wb_we_q, wb_rd_q);
    // No bypass paths and no write-through regfile: wait until the producer is gone.
    assign stall_s  = rs1_ex_s | rs2_ex_s | rs1_mem_s | rs2_mem_s | rs1_wb_s | rs2_wb_s;

    assign bus.fwd_rs1_sel = 2'b00;
    assign bus.fwd_rs2_sel = 2'b00;
`endif

    assign run_s        = (state_q == ST_RUN);
    // A redirect blocks issue, so a squashed ID instruction never reaches the EX tag.
    assign issue_s      = bus.id_valid & ~stall_s & ~bus.ex_redirect & run_s & ~bus.dbg_halt_req;
    // The redirect target must always load, so a redirect overrides every hold reason.
    assign hold_s       = ~bus.ex_redirect & (stall_s | ~run_s | bus.dbg_halt_req);
    assign pipe_empty_s = ~(ex_v_q | mem_v_q | wb_v_q);

    assign bus.pc_stall     = hold_s;
    assign bus.if_id_stall  = hold_s;
    assign bus.if_id_flush  = bus.ex_redirect & FLUSH_EN;
    assign bus.id_ex_bubble = ~issue_s;
    assign bus.halted       = halted_q;
    assign bus.pipe_empty   = pipe_empty_s;

    // Shadow tags advance one stage per clock; EX takes the ID instruction only on issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_v_q    <= 1'b0;
            ex_we_q   <= 1'b0;
            ex_rd_q   <= X0;
            mem_v_q   <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_rd_q  <= X0;
            wb_v_q    <= 1'b0;
`ifdef HAZARD_CTRL_FWD_EN
            ex_ld_q   <= 1'b0;
            fwd_rs1_q <= 2'd0;
            fwd_rs2_q <= 2'd0;
`else
            wb_we_q   <= 1'b0;
            wb_rd_q   <= X0;
`endif
        end else begin
            ex_v_q    <= issue_s;
            ex_we_q   <= issue_s & bus.id_reg_we;
            ex_rd_q   <= issue_s ? bus.id_rd_addr : X0;
            mem_v_q   <= ex_v_q;
            mem_we_q  <= ex_we_q;
            mem_rd_q  <= ex_rd_q;
            wb_v_q    <= mem_v_q;
`ifdef HAZARD_CTRL_FWD_EN
            ex_ld_q   <= issue_s & bus.id_is_load;
            fwd_rs1_q <= fwd_rs1_d;
            fwd_rs2_q <= fwd_rs2_d;
`else
            wb_we_q   <= mem_we_q;
            wb_rd_q   <= mem_rd_q;
`endif
        end
    end

    // Debug halt/drain FSM; halted is registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.dbg_halt_req) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        state_q <= ST_RUN;
                    end
                    halted_q <= 1'b0;
                end
                ST_DRAIN: begin
                    if (pipe_empty_s) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        state_q  <= ST_DRAIN;
                        halted_q <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    if (bus.dbg_resume) begin
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                    end else begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. A timeline model records which instruction
// issued in each cycle; the EX/MEM/WB occupants at cycle t are the
// instructions issued at t-1, t-2 and t-3. Expected outputs come from that
// timeline and are compared on every cycle, and each scenario also pins
// hand-computed literal values. Honours HAZARD_CTRL_FWD_EN like the design.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } ins_t;

`ifdef HAZARD_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    hazard_ctrl_if #(.REG_ADDR_W(5)) bus ();

    hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_ON_REDIRECT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stimulus as the bench applied it this cycle
    ins_t cur       = '0;
    logic cur_redir = 1'b0;
    logic cur_hreq  = 1'b0;
    logic cur_res   = 1'b0;

    // Timeline model
    ins_t       hist [0:1023];
    int         t       = 0;
    int         base    = 0;
    int         mode    = 0;   // 0 running, 1 draining, 2 halted
    logic [1:0] m_f1    = 2'd0;
    logic [1:0] m_f2    = 2'd0;
    logic       m_live  = 1'b0;
    logic       m_issue = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    function automatic ins_t issued_at(input int k);
        if (k < base) return '0;
        return hist[k % 1024];
    endfunction

    // Does the instruction in ID read a register that p writes?
    function automatic logic reads(input ins_t p, input logic [4:0] rs, input logic used);
        return cur.v & used & (rs != 5'd0) & p.v & p.we & (p.rd == rs);
    endfunction

    function automatic logic [1:0] src_sel(input ins_t e, input ins_t m, input logic [4:0] rs, input logic used);
        if (reads(e, rs, used)) return 2'd1;
        if (reads(m, rs, used)) return 2'd2;
        return 2'd0;
    endfunction

    // Compare process: check every cycle against the timeline, then advance it.
    always @(negedge clk) begin
        ins_t       e, m, w;
        logic       dep_e, dep_m, dep_w, st, iss, hold, emp;
        e = issued_at(t - 1);
        m = issued_at(t - 2);
        w = issued_at(t - 3);
        if (reset) begin
            base    = t + 1;
            mode    = 0;
            m_f1    = 2'd0;
            m_f2    = 2'd0;
            m_issue = 1'b0;
            m_live  = 1'b1;
        end else if (m_live) begin
            dep_e = reads(e, cur.rs1, cur.u1) | reads(e, cur.rs2, cur.u2);
            dep_m = reads(m, cur.rs1, cur.u1) | reads(m, cur.rs2, cur.u2);
            dep_w = reads(w, cur.rs1, cur.u1) | reads(w, cur.rs2, cur.u2);
            st    = FWD ? (dep_e & e.ld) : (dep_e | dep_m | dep_w);
            iss   = cur.v & !st & !cur_redir & (mode == 0) & !cur_hreq;
            hold  = !cur_redir & (st | (mode != 0) | cur_hreq);
            emp   = !(e.v | m.v | w.v);
            check("pc_stall",     bus.pc_stall,     hold);
            check("if_id_stall",  bus.if_id_stall,  hold);
            check("if_id_flush",  bus.if_id_flush,  cur_redir);
            check("id_ex_bubble", bus.id_ex_bubble, !iss);
            check("pipe_empty",   bus.pipe_empty,   emp);
            check("halted",       bus.halted,       mode == 2);
            check("fwd_rs1_sel",  bus.fwd_rs1_sel,  m_f1);
            check("fwd_rs2_sel",  bus.fwd_rs2_sel,  m_f2);
            hist[t % 1024] = iss ? cur : '0;
            m_issue = iss;
            m_f1 = (FWD && iss) ? src_sel(e, m, cur.rs1, cur.u1) : 2'd0;
            m_f2 = (FWD && iss) ? src_sel(e, m, cur.rs2, cur.u2) : 2'd0;
            if (mode == 0 && cur_hreq) mode = 1;
            else if (mode == 1 && emp) mode = 2;
            else if (mode == 2 && cur_res) mode = 0;
        end
        t = t + 1;
    end

    function automatic ins_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                                input logic u2, input logic [4:0] rd, input logic we, input logic ld);
        ins_t r;
        r = '{v: 1'b1, rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd, we: we, ld: ld};
        return r;
    endfunction

    // Apply one cycle of stimulus just after the rising edge; return just after the falling edge.
    task automatic cyc(input ins_t in, input logic redir, input logic hreq, input logic res, input logic rs);
        @(posedge clk);
        #1;
        cur              = in;
        cur_redir        = redir;
        cur_hreq         = hreq;
        cur_res          = res;
        reset            = rs;
        bus.id_valid     = in.v;
        bus.id_rs1_addr  = in.rs1;
        bus.id_rs2_addr  = in.rs2;
        bus.id_rs1_used  = in.u1;
        bus.id_rs2_used  = in.u2;
        bus.id_rd_addr   = in.rd;
        bus.id_reg_we    = in.we;
        bus.id_is_load   = in.ld;
        bus.ex_redirect  = redir;
        bus.dbg_halt_req = hreq;
        bus.dbg_resume   = res;
        @(negedge clk);
        #1;
    endtask

    // Hold an instruction in ID until it issues (bounded); n = cycles spent in ID.
    task automatic feed(input ins_t in, output int n);
        n = 0;
        do begin
            cyc(in, 1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end while (!m_issue && n < 8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        ins_t nop;
        ins_t i13;
        nop = '0;
        bus.id_valid = 1'b0;  bus.id_rs1_addr = 5'd0; bus.id_rs2_addr = 5'd0;
        bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0; bus.id_rd_addr = 5'd0;
        bus.id_reg_we = 1'b0; bus.id_is_load = 1'b0; bus.ex_redirect = 1'b0;
        bus.dbg_halt_req = 1'b0; bus.dbg_resume = 1'b0;

        // Reset state
        cyc(nop, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(nop, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(nop, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_pipe_empty", bus.pipe_empty, 1);
        check("rst_halted", bus.halted, 0);
        check("rst_fwd1", bus.fwd_rs1_sel, 0);
        check("rst_fwd2", bus.fwd_rs2_sel, 0);
        check("rst_pc_stall", bus.pc_stall, 0);

        // addi x5,x1 ; add x6,x5,x1
        feed(mk(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0), n);
        check("addi_cycles", n, 1);
        feed(mk(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0), n);
        check("alu_use_cycles", n, FWD ? 1 : 4);
        cyc(nop, 1'b0, 1'b0, 1'b0, 1'b0);
        check("alu_use_fwd1", bus.fwd_rs1_sel, FWD ? 1 : 0);
        check("alu_use_fwd2", bus.fwd_rs2_sel, 0);
        repeat (3) cyc(nop, 1'b0, 1'b0, 1'b0, 1'b0);

        // lw x7,(x2) ; sub x8,x7,x7
        feed(mk(5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1), n);
        feed(mk(5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0), n);
        check("load_use_cycles", n, FWD ? 2 : 4);
        cyc(nop, 1'b0, 1'b0, 1'b0, 1'b0);
        check("load_use_fwd1", bus.fwd_rs1_sel, FWD ? 2 : 0);
        check("load_use_fwd2", bus.fwd_rs2_sel, FWD ? 2 : 0);
        repeat (3) cyc(nop, 1'b0, 1'b0, 1'b0, 1'b0);

        // Writes to x0 never create a dependency
        feed(mk(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0), n);
        feed(mk(5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0), n);
        check("x0_cycles", n, 1);
        cyc(nop, 1'b0, 1'b0, 1'b0, 1'b0);
        check("x0_fwd1", bus.fwd_rs1_sel, 0);
        check("x0_fwd2", bus.fwd_rs2_sel, 0);
        repeat (3) cyc(nop, 1'b0, 1'b0, 1'b0, 1'b0);

        // Redirect while the ID instruction is stalled on a load
        feed(mk(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1), n);
        cyc(mk(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0, 1'b0);
        check("redir_flush", bus.if_id_flush, 1);
        check("redir_bubble", bus.id_ex_bubble, 1);
        check("redir_pc_stall", bus.pc_stall, 0);
        check("redir_if_id_stall", bus.if_id_stall, 0);
        feed(mk(5'd6, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0), n);
        check("redir_squashed_cycles", n, 1);
        cyc(nop, 1'b0, 1'b0, 1'b0, 1'b0);
        check("redir_squashed_fwd1", bus.fwd_rs1_sel, 0);
        repeat (3) cyc(nop, 1'b0, 1'b0, 1'b0, 1'b0);

        // Fill EX/MEM/WB, then halt, drain and resume
        cyc(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        i13 = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
        cyc(i13, 1'b0, 1'b1, 1'b0, 1'b0);
        check("halt_c0_bubble", bus.id_ex_bubble, 1);
        check("halt_c0_pc_stall", bus.pc_stall, 1);
        check("halt_c0_empty", bus.pipe_empty, 0);
        cyc(i13, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(i13, 1'b0, 1'b1, 1'b0, 1'b0);
        check("halt_c2_empty", bus.pipe_empty, 0);
        cyc(i13, 1'b0, 1'b1, 1'b0, 1'b0);
        check("halt_c3_empty", bus.pipe_empty, 1);
        check("halt_c3_halted", bus.halted, 0);
        cyc(i13, 1'b0, 1'b1, 1'b0, 1'b0);
        check("halt_c4_halted", bus.halted, 1);
        cyc(i13, 1'b0, 1'b0, 1'b0, 1'b0);
        check("halt_c5_halted", bus.halted, 1);
        check("halt_c5_bubble", bus.id_ex_bubble, 1);
        cyc(i13, 1'b0, 1'b0, 1'b1, 1'b0);
        check("halt_c6_halted", bus.halted, 1);
        cyc(i13, 1'b0, 1'b0, 1'b0, 1'b0);
        check("resume_halted", bus.halted, 0);
        check("resume_bubble", bus.id_ex_bubble, 0);
        check("resume_pc_stall", bus.pc_stall, 0);
        repeat (3) cyc(nop, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset while draining with MEM occupied
        cyc(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(nop, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(nop, 1'b0, 1'b1, 1'b0, 1'b1);
        check("drain_rst_pre_empty", bus.pipe_empty, 0);
        check("drain_rst_pre_pc_stall", bus.pc_stall, 1);
        cyc(mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd21, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        check("drain_rst_halted", bus.halted, 0);
        check("drain_rst_empty", bus.pipe_empty, 1);
        check("drain_rst_bubble", bus.id_ex_bubble, 0);
        check("drain_rst_pc_stall", bus.pc_stall, 0);
        repeat (2) cyc(nop, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
